seq_div: RTL and testbench

- Multi-cycle, parametrised integer divider for the ALU.
- Computes quotient and remainder with non-restoring division, one quotient bit per clock.
- Selects signed or unsigned mode per operation and uses a start/ready/valid handshake.
- Flags divide-by-zero and signed overflow.
- Packs results as {remainder, quotient} into the HI/LO write path, same as the combinational DIV path.

---
 rtl/seq_div_if.sv | 30 +++
 rtl/seq_div.sv | 154 +++++++++++++++
 tb/tb_seq_div.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_div_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div_if
//  Purpose  : Request/result bundle for the sequential divider.
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      start;
  logic                      signed_op;
  logic [DATA_WIDTH-1:0]     dividend;
  logic [DATA_WIDTH-1:0]     divisor;
  logic                      ready;
  logic                      z_valid;
  logic [2*DATA_WIDTH-1:0]   Z;
  logic                      dbz;
  logic                      ovf;

  modport master (
    output start, signed_op, dividend, divisor,
    input  ready, z_valid, Z, dbz, ovf
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output ready, z_valid, Z, dbz, ovf
  );
endinterface
`default_nettype wire

// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div
//  Purpose  : Non-restoring multi-cycle divider, one quotient bit per clock.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_div #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  seq_div_if.slave   bus
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_prep = 3'd1;
  localparam logic [2:0] c_st_iter = 3'd2;
  localparam logic [2:0] c_st_fix  = 3'd3;
  localparam logic [2:0] c_st_done = 3'd4;

  logic [2:0]               r_state;
  logic                     r_signed;
  logic [DATA_WIDTH:0]      r_a;
  logic [DATA_WIDTH-1:0]    r_q;
  logic [DATA_WIDTH:0]      r_m;
  logic [CNT_WIDTH-1:0]     r_cnt;
  logic                     r_qsign;
  logic                     r_rsign;
  logic                     r_ovf_pend;
  logic                     r_dbz_pend;
  logic [2*DATA_WIDTH-1:0]  r_z;
  logic                     r_z_valid;
  logic                     r_dbz;
  logic                     r_ovf;

  logic                     w_ready;
  logic                     w_accept;
  logic                     w_dvd_neg;
  logic                     w_dvs_neg;
  logic [DATA_WIDTH-1:0]    w_dvd_abs;
  logic [DATA_WIDTH-1:0]    w_dvs_abs;
  logic                     w_dvs_zero;
  logic                     w_ovf_det;
  logic [DATA_WIDTH:0]      w_a_sh;
  logic [DATA_WIDTH:0]      w_a_step;
  logic [DATA_WIDTH-1:0]    w_rem_mag;
  logic [DATA_WIDTH-1:0]    w_rem;
  logic [DATA_WIDTH-1:0]    w_quo;

  assign w_ready  = (r_state == c_st_idle) || (r_state == c_st_done);
  assign w_accept = w_ready && bus.start;

  // Operand magnitudes; in PREP r_q/r_m still hold the raw captured operands.
  assign w_dvd_neg  = r_signed & r_q[DATA_WIDTH-1];
  assign w_dvs_neg  = r_signed & r_m[DATA_WIDTH-1];
  assign w_dvd_abs  = w_dvd_neg ? (-r_q) : r_q;
  assign w_dvs_abs  = w_dvs_neg ? (-r_m[DATA_WIDTH-1:0]) : r_m[DATA_WIDTH-1:0];
  assign w_dvs_zero = (r_m[DATA_WIDTH-1:0] == '0);
  assign w_ovf_det  = r_signed
                    && (r_q == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                    && (r_m[DATA_WIDTH-1:0] == '1);

  // Add/subtract decision uses the sign of A before the shift, which is
  // immune to the wrap the shifted intermediate can suffer.
  assign w_a_sh   = {r_a[DATA_WIDTH-1:0], r_q[DATA_WIDTH-1]};
  assign w_a_step = r_a[DATA_WIDTH] ? (w_a_sh + r_m) : (w_a_sh - r_m);

  assign w_rem_mag = r_a[DATA_WIDTH] ? (r_a[DATA_WIDTH-1:0] + r_m[DATA_WIDTH-1:0])
                                     : r_a[DATA_WIDTH-1:0];
  assign w_rem     = r_rsign ? (-w_rem_mag) : w_rem_mag;
  assign w_quo     = r_qsign ? (-r_q) : r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_signed   <= 1'b0;
      r_a        <= '0;
      r_q        <= '0;
      r_m        <= '0;
      r_cnt      <= '0;
      r_qsign    <= 1'b0;
      r_rsign    <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_z        <= '0;
      r_z_valid  <= 1'b0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_z_valid <= 1'b0;
      case (r_state)
        c_st_prep: begin
          r_a        <= '0;
          r_cnt      <= CNT_WIDTH'(DATA_WIDTH);
          r_qsign    <= w_dvd_neg ^ w_dvs_neg;
          r_rsign    <= w_dvd_neg;
          r_ovf_pend <= w_ovf_det;
          r_m        <= {1'b0, w_dvs_abs};
          if (w_dvs_zero) begin
            // Raw dividend stays in r_q for the remainder field.
            r_dbz_pend <= 1'b1;
            r_state    <= c_st_done;
          end else begin
            r_q     <= w_dvd_abs;
            r_state <= c_st_iter;
          end
        end
        c_st_iter: begin
          r_a   <= w_a_step;
          r_q   <= {r_q[DATA_WIDTH-2:0], ~w_a_step[DATA_WIDTH]};
          r_cnt <= r_cnt - CNT_WIDTH'(1);
          if (r_cnt == CNT_WIDTH'(1)) begin
            r_state <= c_st_fix;
          end
        end
        c_st_fix: begin
          r_z       <= {w_rem, w_quo};
          r_dbz     <= 1'b0;
          r_ovf     <= r_ovf_pend;
          r_z_valid <= 1'b1;
          r_state   <= c_st_done;
        end
        c_st_done: begin
          if (r_dbz_pend) begin
            r_z        <= {r_q, {DATA_WIDTH{1'b1}}};
            r_dbz      <= 1'b1;
            r_ovf      <= 1'b0;
            r_z_valid  <= 1'b1;
            r_dbz_pend <= 1'b0;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase

      if (w_accept) begin
        r_q      <= bus.dividend;
        r_m      <= {1'b0, bus.divisor};
        r_signed <= bus.signed_op;
        r_state  <= c_st_prep;
      end
    end
  end

  assign bus.ready   = w_ready;
  assign bus.z_valid = r_z_valid;
  assign bus.Z       = r_z;
  assign bus.dbz     = r_dbz;
  assign bus.ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_div
//  Purpose  : Randomised self-checking bench for seq_div against an
//             arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_div;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_div_if #(.DATA_WIDTH(W)) bus ();

  seq_div #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int unsigned    due;
    logic [2*W-1:0] z;
    logic           dbz;
    logic           ovf;
  } exp_t;

  exp_t           exp_q[$];
  int unsigned    ecnt = 0;
  int             n_cmp = 0;
  int             n_fail = 0;
  logic [2*W-1:0] hold_z = '0;
  logic           hold_dbz = 1'b0;
  logic           hold_ovf = 1'b0;
  logic           exp_rdy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, req, ecnt);
    end
  endtask

  // Result rules from arithmetic: C-style truncating division, remainder
  // takes the dividend sign; divide-by-zero and MIN/-1 are special values.
  function automatic exp_t model(input bit s, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int unsigned acc_edge);
    exp_t e;
    int   sa, sb, q, r;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == '0) begin
      e.z   = {a, {W{1'b1}}};
      e.dbz = 1'b1;
      e.due = acc_edge + 2;
    end else begin
      e.due = acc_edge + W + 2;
      if (s) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.z   = {32'h0, 32'h8000_0000};
          e.ovf = 1'b1;
        end else begin
          sa  = $signed(a);
          sb  = $signed(b);
          q   = sa / sb;
          r   = sa % sb;
          e.z = {r[W-1:0], q[W-1:0]};
        end
      end else begin
        e.z = {a % b, a / b};
      end
    end
    return e;
  endfunction

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_z   = '0;
      hold_dbz = 1'b0;
      hold_ovf = 1'b0;
      chk("rst_ready",   bus.ready,   1);
      chk("rst_z_valid", bus.z_valid, 0);
      chk("rst_Z",       bus.Z,       0);
      chk("rst_dbz",     bus.dbz,     0);
      chk("rst_ovf",     bus.ovf,     0);
    end else begin
      if (exp_q.size() != 0 && exp_q[0].due == ecnt) begin
        chk("z_valid_pulse", bus.z_valid, 1);
        chk("Z",   bus.Z,   exp_q[0].z);
        chk("dbz", bus.dbz, exp_q[0].dbz);
        chk("ovf", bus.ovf, exp_q[0].ovf);
        hold_z   = exp_q[0].z;
        hold_dbz = exp_q[0].dbz;
        hold_ovf = exp_q[0].ovf;
        void'(exp_q.pop_front());
      end else begin
        chk("z_valid_quiet", bus.z_valid, 0);
        chk("Z_hold",   bus.Z,   hold_z);
        chk("dbz_hold", bus.dbz, hold_dbz);
        chk("ovf_hold", bus.ovf, hold_ovf);
      end
      exp_rdy = (exp_q.size() == 0) || (exp_q[0].dbz && exp_q[0].due == ecnt + 1);
      chk("ready", bus.ready, exp_rdy);
      if (bus.ready && bus.start)
        exp_q.push_back(model(bus.signed_op, bus.dividend, bus.divisor, ecnt + 1));
    end
  end

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom % 8)
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return W'($urandom % 16);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic scramble();
    bus.signed_op = 1'($urandom);
    bus.dividend  = rand_opnd();
    bus.divisor   = rand_opnd();
  endtask

  task automatic do_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_op = s; bus.dividend = a; bus.divisor = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ready) begin acc = 1'b1; break; end
    end
    if (!acc) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble();
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin empty = 1'b1; break; end
    end
    if (!empty) chk("drain_timeout", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    exp_t m;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Hand-computed values that pin the reference model.
    m = model(1, 32'hFFFF_FFF9, 32'd2, 0);
    chk("pin_m7_div2", m.z, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_lat_norm", m.due, 34);
    m = model(0, 32'hFFFF_FFFF, 32'd2, 0);
    chk("pin_u_div2", m.z, 64'h0000_0001_7FFF_FFFF);
    m = model(1, 32'hFFFF_FFFF, 32'd2, 0);
    chk("pin_s_m1_div2", m.z, 64'hFFFF_FFFF_0000_0000);
    m = model(0, 32'd100, 32'd0, 0);
    chk("pin_dbz", {m.z, m.dbz}, {64'h0000_0064_FFFF_FFFF, 1'b1});
    chk("pin_lat_dbz", m.due, 2);
    m = model(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("pin_ovf", {m.z, m.ovf}, {64'h0000_0000_8000_0000, 1'b1});

    // Directed test-plan operations, each checked against a literal too.
    do_op(1, 32'hFFFF_FFF9, 32'd2);           drain();
    chk("dut_m7_div2", bus.Z, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(0, 32'hFFFF_FFFF, 32'd2);           drain();
    chk("dut_u_div2", bus.Z, 64'h0000_0001_7FFF_FFFF);
    do_op(1, 32'hFFFF_FFFF, 32'd2);           drain();
    chk("dut_s_div2", bus.Z, 64'hFFFF_FFFF_0000_0000);
    do_op(0, 32'd100, 32'd0);                 drain();
    chk("dut_dbz", {bus.Z, bus.dbz, bus.ovf}, {64'h0000_0064_FFFF_FFFF, 2'b10});
    do_op(1, 32'h8000_0000, 32'hFFFF_FFFF);   drain();
    chk("dut_ovf", {bus.Z, bus.dbz, bus.ovf}, {64'h0000_0000_8000_0000, 2'b01});
    do_op(1, 32'd100, 32'd7);
    do_op(1, -32'sd100, 32'd7);               drain();
    chk("dut_m100_div7", bus.Z, 64'hFFFF_FFFE_FFFF_FFF2);

    // Reset in the middle of an iteration.
    do_op(0, 32'd1000, 32'd3);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", bus.ready, 1);
    chk("midrst_outs", {bus.z_valid, bus.dbz, bus.ovf}, 0);
    chk("midrst_Z", bus.Z, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_op(0, 32'd50, 32'd5);                  drain();
    chk("dut_50_div5", bus.Z, 64'h0000_0000_0000_000A);

    // start held high: a new op is taken in every DONE cycle.
    @(posedge clk); #1;
    bus.start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      scramble();
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    drain();

    // Random start pulses, many landing while busy.
    for (int i = 0; i < 1500; i++) begin
      bus.start = ($urandom % 3 == 0);
      scramble();
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
